// File: rtl/fpu_share_arbiter.sv
// Round-robin sharing of one combinational floating_alu between NUM_REQ requesters.
// Optional statistics counters are enabled with the FPU_ARB_STATS_EN macro.

package fpu_arb_pkg;
    typedef enum logic [2:0] {
        FADD = 3'd0,
        FSUB = 3'd1,
        FMUL = 3'd2,
        FDIV = 3'd3
    } alu_instruction_t;
endpackage

// Single-precision ALU: normal numbers only, denormals flush to zero, results truncate.
module floating_alu
    import fpu_arb_pkg::*;
(
    input  logic [31:0]      op1,
    input  logic [31:0]      op2,
    input  alu_instruction_t instr,
    output logic [31:0]      result
);
    logic        sa, sb, s_r, a_zero, b_zero, a_big, op_ok, zero_r, inf_r, unused_bits;
    logic [23:0] ma, mb, m_big, m_sml;
    logic [24:0] sum, norm, quot;
    logic [47:0] prod;
    logic [22:0] frac;
    int          ea, eb, e_r, diff, msb;

    always_comb begin
        sa     = op1[31];
        sb     = op2[31] ^ (instr == FSUB);
        ea     = int'(op1[30:23]);
        eb     = int'(op2[30:23]);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        ma     = {~a_zero, op1[22:0]};
        mb     = {~b_zero, op2[22:0]};
        // Zero operands fall through the add path naturally: their mantissa is 0.
        a_big  = (op1[30:0] >= op2[30:0]);
        m_big  = a_big ? ma : mb;
        diff   = a_big ? (ea - eb) : (eb - ea);
        m_sml  = (diff > 23) ? '0 : ((a_big ? mb : ma) >> diff);
        sum    = (sa == sb) ? ({1'b0, m_big} + {1'b0, m_sml}) : ({1'b0, m_big} - {1'b0, m_sml});
        msb    = 0;
        for (int i = 0; i < 25; i++) begin
            if (sum[i]) msb = i;
        end
        norm   = sum << (24 - msb);
        prod   = 48'(ma) * 48'(mb);
        quot   = 25'({ma, 24'h0} / (b_zero ? 48'd1 : 48'(mb)));
        unused_bits = ^{prod[22:0], norm[24], norm[0]};

        op_ok  = 1'b1;
        zero_r = 1'b0;
        inf_r  = 1'b0;
        s_r    = 1'b0;
        e_r    = 0;
        frac   = '0;
        result = '0;
        case (instr)
            FADD, FSUB: begin
                s_r    = a_big ? sa : sb;
                zero_r = (sum == '0);
                e_r    = (a_big ? ea : eb) + msb - 23;
                frac   = norm[23:1];
            end
            FMUL: begin
                s_r    = op1[31] ^ op2[31];
                zero_r = a_zero | b_zero;
                e_r    = prod[47] ? (ea + eb - 126) : (ea + eb - 127);
                frac   = prod[47] ? prod[46:24] : prod[45:23];
            end
            FDIV: begin
                s_r    = op1[31] ^ op2[31];
                zero_r = a_zero;
                inf_r  = b_zero & ~a_zero;
                e_r    = quot[24] ? (ea - eb + 127) : (ea - eb + 126);
                frac   = quot[24] ? quot[23:1] : quot[22:0];
            end
            default: op_ok = 1'b0;
        endcase

        if (!op_ok || zero_r || (!inf_r && e_r <= 0)) begin
            result = '0;
        end else if (inf_r || e_r >= 255) begin
            result = {s_r, 8'hFF, 23'h0};
        end else begin
            result = {s_r, e_r[7:0], frac};
        end
    end
endmodule

module fpu_share_arbiter
    import fpu_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DIV_CYCLES = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req_valid,
    output logic [NUM_REQ-1:0]                       req_ready,
    input  logic [NUM_REQ*32-1:0]                    req_op1,
    input  logic [NUM_REQ*32-1:0]                    req_op2,
    input  logic [NUM_REQ*$bits(alu_instruction_t)-1:0] req_instr,
    output logic [NUM_REQ-1:0]                       resp_valid,
    input  logic [NUM_REQ-1:0]                       resp_ready,
    output logic [31:0]                              resp_result,
    output logic                                     busy
`ifdef FPU_ARB_STATS_EN
    ,
    input  logic                                     stat_clear,
    output logic [31:0]                              stat_grants,
    output logic [31:0]                              stat_stalls
`endif
);
    localparam int IW    = $bits(alu_instruction_t);
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d, owner_q, owner_d, grant_idx, scan_idx;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [31:0]          op1_q, op1_d, op2_q, op2_d, res_q, res_d, alu_result;
    logic [IW-1:0]        instr_q, instr_d, grant_instr;
    logic [NUM_REQ-1:0]   rv_q, rv_d;
    logic                 grant_found, grant_fire;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        grant_fire  = (state_q == S_IDLE) && grant_found;
        grant_instr = req_instr[int'(grant_idx)*IW +: IW];
    end

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a response stays stable until its ready is seen.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        instr_d   = instr_q;
        res_d     = res_q;
        rv_d      = rv_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_fire) begin
                    req_ready[grant_idx] = rst_n;
                    op1_d    = req_op1[int'(grant_idx)*32 +: 32];
                    op2_d    = req_op2[int'(grant_idx)*32 +: 32];
                    instr_d  = grant_instr;
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d    = (grant_instr == FDIV) ? CNT_W'(DIV_CYCLES - 1) : '0;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    res_d          = alu_result;
                    rv_d           = '0;
                    rv_d[owner_q]  = 1'b1;
                    state_d        = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready[owner_q]) begin
                    rv_d    = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            instr_q  <= '0;
            res_q    <= '0;
            rv_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            instr_q  <= instr_d;
            res_q    <= res_d;
            rv_q     <= rv_d;
        end
    end

    floating_alu u_alu (
        .op1    (op1_q),
        .op2    (op2_q),
        .instr  (alu_instruction_t'(instr_q)),
        .result (alu_result)
    );

    assign resp_valid  = rv_q;
    assign resp_result = res_q;
    assign busy        = (state_q != S_IDLE);

`ifdef FPU_ARB_STATS_EN
    logic [31:0] stat_grants_q, stat_grants_d, stat_stalls_q, stat_stalls_d;

    always_comb begin
        stat_grants_d = stat_grants_q;
        stat_stalls_d = stat_stalls_q;
        if (stat_clear) begin
            stat_grants_d = '0;
            stat_stalls_d = '0;
        end else begin
            if (grant_fire) stat_grants_d = stat_grants_q + 32'd1;
            if (|req_valid && !grant_fire) stat_stalls_d = stat_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_grants_q <= '0;
            stat_stalls_q <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_stalls_q <= stat_stalls_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_stalls = stat_stalls_q;
`endif
endmodule
